// File: rtl/bidir_io_cfg_pkg.sv
// Shared definitions for the bidir_io configuration controller: sequencer states,
// register addresses and STATUS bit positions.
package bidir_io_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_APPLY   = 3'd3,
        ST_SETTLE  = 3'd4
    } cfg_state_e;

    localparam logic [7:0] ADDR_ENA_LO = 8'h40;
    localparam logic [7:0] ADDR_ENA_HI = 8'h41;
    localparam logic [7:0] ADDR_OD_LO  = 8'h42;
    localparam logic [7:0] ADDR_OD_HI  = 8'h43;
    localparam logic [7:0] ADDR_CTRL   = 8'h44;
    localparam logic [7:0] ADDR_STATUS = 8'h45;

    localparam int STATUS_BUSY_BIT       = 0;
    localparam int STATUS_PENDING_BIT    = 1;
    localparam int STATUS_WR_DROPPED_BIT = 2;
    localparam int CTRL_COMMIT_BIT       = 0;

    // True for the four words that hold the enable / open-drain shadow halves.
    function automatic logic is_mask_addr(input logic [7:0] addr);
        return (addr >= ADDR_ENA_LO) && (addr <= ADDR_OD_HI);
    endfunction

endpackage

// File: rtl/bidir_io_cfg_regs.sv
// Shadow register file and registered read mux. Shadow writes are refused while
// the sequencer is running so the values being applied cannot change under it.
module bidir_io_cfg_regs
    import bidir_io_cfg_pkg::*;
#(
    parameter int IOWidth      = 36,
    parameter int PortNumWidth = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [7:0]                            bus_addr,
    input  logic [31:0]                           bus_wdata,
    input  logic                                  bus_wr,
    input  logic                                  bus_rd,
    input  logic                                  lock,
    input  logic                                  busy,
    input  logic                                  pending,
    output logic [IOWidth-1:0][PortNumWidth-1:0]  shadow_psel,
    output logic [IOWidth-1:0]                    shadow_ena,
    output logic [IOWidth-1:0]                    shadow_od,
    output logic                                  commit,
    output logic [31:0]                           bus_rdata
);

    logic [IOWidth-1:0][PortNumWidth-1:0] psel_r;
    logic [IOWidth-1:0]                   ena_r;
    logic [IOWidth-1:0]                   od_r;
    logic                                 wr_dropped_r;
    logic [31:0]                          rdata_r;

    logic        psel_hit_s;
    logic        shadow_wr_s;
    logic        wr_ok_s;
    logic        status_rd_s;
    logic        commit_s;
    logic [63:0] ena_pad_s;
    logic [63:0] od_pad_s;
    logic [31:0] status_s;
    logic [31:0] rd_mux_s;

    // Merge one 32-bit half into a pin-wide mask; bits beyond IOWidth simply do not exist.
    function automatic logic [IOWidth-1:0] merge_half(input logic [IOWidth-1:0] cur,
                                                     input logic wr_lo, input logic wr_hi,
                                                     input logic [31:0] wdata);
        logic [IOWidth-1:0] nxt;
        for (int i = 0; i < IOWidth; i++) begin
            if (i < 32) begin
                nxt[i] = wr_lo ? wdata[i % 32] : cur[i];
            end else begin
                nxt[i] = wr_hi ? wdata[i % 32] : cur[i];
            end
        end
        return nxt;
    endfunction

    // Address decode for shadow writes, commit requests and STATUS reads.
    always_comb begin
        psel_hit_s  = ({24'd0, bus_addr} < 32'(IOWidth));
        shadow_wr_s = bus_wr & (psel_hit_s | is_mask_addr(bus_addr));
        wr_ok_s     = shadow_wr_s & ~lock;
        status_rd_s = bus_rd & (bus_addr == ADDR_STATUS);
        commit_s    = bus_wr & (bus_addr == ADDR_CTRL) & bus_wdata[CTRL_COMMIT_BIT];
    end

    // Read mux; unmapped words and bits above IOWidth read as zero.
    always_comb begin
        ena_pad_s = 64'(ena_r);
        od_pad_s  = 64'(od_r);
        status_s  = 32'd0;
        status_s[STATUS_BUSY_BIT]       = busy;
        status_s[STATUS_PENDING_BIT]    = pending;
        status_s[STATUS_WR_DROPPED_BIT] = wr_dropped_r;
        rd_mux_s  = 32'd0;
        case (bus_addr)
            ADDR_ENA_LO: rd_mux_s = ena_pad_s[31:0];
            ADDR_ENA_HI: rd_mux_s = ena_pad_s[63:32];
            ADDR_OD_LO:  rd_mux_s = od_pad_s[31:0];
            ADDR_OD_HI:  rd_mux_s = od_pad_s[63:32];
            ADDR_CTRL:   rd_mux_s = 32'd0;
            ADDR_STATUS: rd_mux_s = status_s;
            default: begin
                for (int i = 0; i < IOWidth; i++) begin
                    rd_mux_s = rd_mux_s | ((bus_addr == 8'(i)) ? 32'(psel_r[i]) : 32'd0);
                end
            end
        endcase
    end

    // Shadow register file, identity port mapping out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IOWidth; i++) begin
                psel_r[i] <= PortNumWidth'(i);
            end
            ena_r <= {IOWidth{1'b0}};
            od_r  <= {IOWidth{1'b0}};
        end else if (wr_ok_s) begin
            for (int i = 0; i < IOWidth; i++) begin
                if (bus_addr == 8'(i)) begin
                    psel_r[i] <= bus_wdata[PortNumWidth-1:0];
                end
            end
            ena_r <= merge_half(ena_r, bus_addr == ADDR_ENA_LO, bus_addr == ADDR_ENA_HI, bus_wdata);
            od_r  <= merge_half(od_r, bus_addr == ADDR_OD_LO, bus_addr == ADDR_OD_HI, bus_wdata);
        end
    end

    // Sticky dropped-write flag; a new drop wins over a clearing STATUS read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_dropped_r <= 1'b0;
        end else if (shadow_wr_s & lock) begin
            wr_dropped_r <= 1'b1;
        end else if (status_rd_s) begin
            wr_dropped_r <= 1'b0;
        end
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= 32'd0;
        end else if (bus_rd) begin
            rdata_r <= rd_mux_s;
        end
    end

    assign shadow_psel = psel_r;
    assign shadow_ena  = ena_r;
    assign shadow_od   = od_r;
    assign commit      = commit_s;
    assign bus_rdata   = rdata_r;

endmodule

// File: rtl/bidir_io_cfg.sv
// Pin configuration controller: shadow registers plus a break-before-make commit
// sequencer driving the active portselnum / out_ena / od registers of bidir_io.
module bidir_io_cfg
    import bidir_io_cfg_pkg::*;
#(
    parameter int IOWidth      = 36,
    parameter int PortNumWidth = 8,
    parameter int DrainCycles  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [7:0]                            bus_addr,
    input  logic [31:0]                           bus_wdata,
    input  logic                                  bus_wr,
    input  logic                                  bus_rd,
    output logic [31:0]                           bus_rdata,
    output logic                                  busy,
    output logic [IOWidth-1:0][PortNumWidth-1:0]  portselnum,
    output logic [IOWidth-1:0]                    out_ena,
    output logic [IOWidth-1:0]                    od
);

    localparam int CntWidth = (DrainCycles < 2) ? 1 : $clog2(DrainCycles);
    localparam logic [CntWidth-1:0] DRAIN_LOAD = CntWidth'(DrainCycles - 1);

    cfg_state_e                           state_r;
    logic [CntWidth-1:0]                  drain_cnt_r;
    logic                                 busy_r;
    logic                                 pending_r;
    logic [IOWidth-1:0][PortNumWidth-1:0] act_psel_r;
    logic [IOWidth-1:0]                   act_ena_r;
    logic [IOWidth-1:0]                   act_od_r;

    logic [IOWidth-1:0][PortNumWidth-1:0] shadow_psel_s;
    logic [IOWidth-1:0]                   shadow_ena_s;
    logic [IOWidth-1:0]                   shadow_od_s;
    logic [IOWidth-1:0][PortNumWidth-1:0] apply_psel_s;
    logic [IOWidth-1:0]                   chg_s;
    logic                                 commit_s;
    logic                                 lock_s;

    bidir_io_cfg_regs #(
        .IOWidth      (IOWidth),
        .PortNumWidth (PortNumWidth)
    ) u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .lock        (lock_s),
        .busy        (busy_r),
        .pending     (pending_r),
        .shadow_psel (shadow_psel_s),
        .shadow_ena  (shadow_ena_s),
        .shadow_od   (shadow_od_s),
        .commit      (commit_s),
        .bus_rdata   (bus_rdata)
    );

    // Pins whose source or drive type will change, and the clamped select values to apply.
    always_comb begin
        lock_s = (state_r != ST_IDLE);
        chg_s  = {IOWidth{1'b0}};
        for (int i = 0; i < IOWidth; i++) begin
            chg_s[i] = (shadow_psel_s[i] != act_psel_r[i]) | (shadow_od_s[i] != act_od_r[i]);
            if (32'(shadow_psel_s[i]) < 32'(IOWidth)) begin
                apply_psel_s[i] = shadow_psel_s[i];
            end else begin
                apply_psel_s[i] = PortNumWidth'(i);
            end
        end
    end

    // Commit sequencer; every action takes effect on the edge that leaves its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= {CntWidth{1'b0}};
            busy_r      <= 1'b0;
            pending_r   <= 1'b0;
            for (int i = 0; i < IOWidth; i++) begin
                act_psel_r[i] <= PortNumWidth'(i);
            end
            act_ena_r <= {IOWidth{1'b0}};
            act_od_r  <= {IOWidth{1'b0}};
        end else begin
            if ((state_r != ST_IDLE) && commit_s) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (commit_s || pending_r) begin
                        pending_r <= 1'b0;
                        state_r   <= ST_QUIESCE;
                    end
                end
                ST_QUIESCE: begin
                    act_ena_r   <= act_ena_r & ~chg_s;
                    busy_r      <= 1'b1;
                    drain_cnt_r <= DRAIN_LOAD;
                    state_r     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == {CntWidth{1'b0}}) begin
                        state_r <= ST_APPLY;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - {{(CntWidth-1){1'b0}}, 1'b1};
                    end
                end
                ST_APPLY: begin
                    act_psel_r <= apply_psel_s;
                    act_od_r   <= shadow_od_s;
                    state_r    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    act_ena_r <= shadow_ena_s;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign portselnum = act_psel_r;
    assign out_ena    = act_ena_r;
    assign od         = act_od_r;

endmodule

// File: tb/tb_bidir_io_cfg.sv
// Randomised bench for bidir_io_cfg: a timing-rule reference model feeds a read
// scoreboard and a per-cycle check of the active pin configuration.
module tb_bidir_io_cfg;

    localparam int IOW = 36;
    localparam int PNW = 8;
    localparam int D   = 2;
    localparam logic [63:0] IO_MASK = (64'd1 << IOW) - 64'd1;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [7:0]                 bus_addr;
    logic [31:0]                bus_wdata;
    logic                       bus_wr;
    logic                       bus_rd;
    logic [31:0]                bus_rdata;
    logic                       busy;
    logic [IOW-1:0][PNW-1:0]    portselnum;
    logic [IOW-1:0]             out_ena;
    logic [IOW-1:0]             od;

    always #5 clk = ~clk;

    bidir_io_cfg #(.IOWidth(IOW), .PortNumWidth(PNW), .DrainCycles(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .portselnum (portselnum),
        .out_ena    (out_ena),
        .od         (od)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          edge_n;
        logic [31:0] exp;
        logic [7:0]  addr;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    // Reference model: shadow and active configuration plus the schedule of one run.
    int          m_sh_psel[64];
    int          m_act_psel[64];
    logic [63:0] m_sh_ena, m_sh_od, m_act_ena, m_act_od;
    bit          m_busy, m_pending, m_drop, run_active;
    int          run_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (int'(a) < IOW) v = 32'(m_sh_psel[a]);
        else begin
            case (a)
                8'h40:   v = m_sh_ena[31:0];
                8'h41:   v = m_sh_ena[63:32];
                8'h42:   v = m_sh_od[31:0];
                8'h43:   v = m_sh_od[63:32];
                8'h45:   v = {29'd0, m_drop, m_pending, m_busy};
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_sh_psel[i]  = i;
            m_act_psel[i] = i;
        end
        m_sh_ena = 64'd0; m_sh_od = 64'd0; m_act_ena = 64'd0; m_act_od = 64'd0;
        m_busy = 1'b0; m_pending = 1'b0; m_drop = 1'b0; run_active = 1'b0; run_t = 0;
        sb_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        int k;
        bit locked, start;
        logic [63:0] chg;
        cyc++;
        k = cyc;
        if (bus_rd) sb_q.push_back('{k, model_read(bus_addr), bus_addr});
        locked = run_active;
        if (run_active) begin
            if (k == run_t + 1) begin
                m_busy = 1'b1;
                chg = 64'd0;
                for (int i = 0; i < IOW; i++)
                    if (m_sh_psel[i] != m_act_psel[i] || m_sh_od[i] != m_act_od[i]) chg[i] = 1'b1;
                m_act_ena = m_act_ena & ~chg;
            end
            if (k == run_t + D + 2) begin
                for (int i = 0; i < IOW; i++)
                    m_act_psel[i] = (m_sh_psel[i] >= IOW) ? i : m_sh_psel[i];
                m_act_od = m_sh_od;
            end
            if (k == run_t + D + 3) begin
                m_act_ena  = m_sh_ena;
                m_busy     = 1'b0;
                run_active = 1'b0;
            end
        end
        start = 1'b0;
        if (bus_rd && bus_addr == 8'h45) m_drop = 1'b0;
        if (bus_wr) begin
            if (int'(bus_addr) < IOW || (bus_addr >= 8'h40 && bus_addr <= 8'h43)) begin
                if (locked) m_drop = 1'b1;
                else if (int'(bus_addr) < IOW) m_sh_psel[bus_addr] = int'(bus_wdata[PNW-1:0]);
                else begin
                    case (bus_addr)
                        8'h40:   m_sh_ena = {m_sh_ena[63:32], bus_wdata} & IO_MASK;
                        8'h41:   m_sh_ena = {bus_wdata, m_sh_ena[31:0]} & IO_MASK;
                        8'h42:   m_sh_od  = {m_sh_od[63:32], bus_wdata} & IO_MASK;
                        default: m_sh_od  = {bus_wdata, m_sh_od[31:0]} & IO_MASK;
                    endcase
                end
            end
            if (bus_addr == 8'h44 && bus_wdata[0]) begin
                if (locked) m_pending = 1'b1;
                else start = 1'b1;
            end
        end
        if (!locked && (start || m_pending)) begin
            run_active = 1'b1;
            run_t      = k;
            m_pending  = 1'b0;
        end
    endtask

    // Monitor: compares the pin configuration every cycle and pops read expectations.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            chk("out_ena", 64'(out_ena), m_act_ena);
            chk("od", 64'(od), m_act_od);
            chk("busy", 64'(busy), 64'(m_busy));
            for (int i = 0; i < IOW; i++)
                chk($sformatf("portselnum[%0d]", i), 64'(portselnum[i]), 64'(m_act_psel[i]));
            if (sb_q.size() > 0 && sb_q[0].edge_n == cyc) begin
                e = sb_q.pop_front();
                chk($sformatf("rdata@%0h", e.addr), 64'(bus_rdata), 64'(e.exp));
            end
        end
    end

    task automatic bus_cycle(input logic [7:0] a, input logic [31:0] wd, input logic wr, input logic rd);
        bus_addr = a; bus_wdata = wd; bus_wr = wr; bus_rd = rd;
        @(posedge clk);
        model_step();
        #1;
        bus_wr = 1'b0; bus_rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        bus_cycle(a, d, 1'b1, 1'b0);
    endtask

    task automatic rd_reg(input logic [7:0] a);
        bus_cycle(a, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(8'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bus_addr = 8'd0; bus_wdata = 32'd0; bus_wr = 1'b0; bus_rd = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd_reg(8'h05);
        rd_reg(8'h40);
        // Enable four pins from the identity mapping: nothing masks.
        wr_reg(8'h40, 32'hF);
        wr_reg(8'h44, 32'h1);
        idle(7);
        chk("tp_ena_f", 64'(out_ena), 64'hF);
        // Re-route pin 1: only it drops during the sequence.
        wr_reg(8'h01, 32'd3);
        wr_reg(8'h44, 32'h1);
        idle(7);
        chk("tp_psel1", 64'(portselnum[1]), 64'd3);
        // Out-of-range select falls back to the pin's own index.
        wr_reg(8'h02, 32'd200);
        wr_reg(8'h44, 32'h1);
        idle(7);
        chk("tp_psel2", 64'(portselnum[2]), 64'd2);
        rd_reg(8'h02);
        // Dropped write plus collapsed commits during a run.
        wr_reg(8'h44, 32'h1);
        wr_reg(8'h00, 32'd7);
        wr_reg(8'h44, 32'h1);
        wr_reg(8'h44, 32'h1);
        rd_reg(8'h45);
        idle(14);
        rd_reg(8'h45);
        rd_reg(8'h00);
        // Simultaneous read and write of the same word returns the old value.
        bus_cycle(8'h40, 32'h3, 1'b1, 1'b1);
        rd_reg(8'h40);
        // Reset in the middle of a commit.
        wr_reg(8'h44, 32'h1);
        idle(2);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_ena", 64'(out_ena), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", 64'(bus_rdata), 64'd0);
        for (int i = 0; i < IOW; i++)
            chk($sformatf("rst_psel[%0d]", i), 64'(portselnum[i]), 64'(i));
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] a;
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'(8'h40 + $urandom_range(0, 6));
            case (r)
                0, 1, 2: wr_reg(8'($urandom_range(0, 39)),
                                ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)));
                3:       wr_reg(8'(8'h40 + $urandom_range(0, 3)), $urandom);
                4:       wr_reg(8'h44, 32'($urandom_range(0, 3)));
                5, 6:    rd_reg(a);
                7:       bus_cycle(a, $urandom, 1'b1, 1'b1);
                default: idle(1);
            endcase
        end
        idle(12);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bidir_io_cfg.md
# bidir_io_cfg

Host-programmable configuration controller for the `bidir_io` pin block. It holds shadow copies of every pin's `portselnum`, output enable and open-drain select, and applies them atomically on a commit. The commit runs a break-before-make sequence, so no pin is driven while its source mux is being switched. It sits between the host register bus and `bidir_io`, and its outputs connect straight to that block's `portselnum`, `out_ena` and `od` inputs.

## Interface
Parameters:
- `IOWidth`, default 36: number of pins; legal range 1–64.
- `PortNumWidth`, default 8: width of each port-select entry.
- `DrainCycles`, default 2: number of cycles pins stay tristated before the mux switches; must be ≥1.

Ports:
- `clk`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `bus_addr`  in  8: word address.
- `bus_wdata`  in  32: write data.
- `bus_wr`  in  1: write strobe; one cycle per access.
- `bus_rd`  in  1: read strobe; one cycle per access.
- `bus_rdata`  out  32: read data, registered.
- `busy`  out  1: a commit sequence is in progress.
- `portselnum`  out  [PortNumWidth-1:0] x [IOWidth-1:0]: active port select for each pin.
- `out_ena`  out  IOWidth: active output enables.
- `od`  out  IOWidth: active open-drain selects.

## Operation
Register map:
- 0x00..IOWidth-1: shadow `portselnum[i]`, using bits [PortNumWidth-1:0].
- 0x40 / 0x41: shadow `out_ena` bits [31:0] / [63:32].
- 0x42 / 0x43: shadow `od` bits [31:0] / [63:32].
- 0x44 CTRL: writing bit0=1 requests a commit. Reads return 0.
- 0x45 STATUS: bit0 = `busy`, bit1 = `pending`, bit2 = `wr_dropped`. Reading STATUS clears `wr_dropped`.
- Unmapped addresses: reads return 0, writes are ignored. Bits above IOWidth read 0.

Reset state, for both shadow and active registers:
- `portselnum[i]` = i (identity mapping).
- `out_ena` = 0, `od` = 0.
- `busy` = 0, `pending` = 0, `wr_dropped` = 0, `bus_rdata` = 0.

State machine: IDLE -> QUIESCE -> DRAIN -> APPLY -> SETTLE -> IDLE.
- IDLE: a CTRL commit, or `pending`=1, moves to QUIESCE and clears `pending`.
- QUIESCE: latches `chg[i]` = (shadow `portselnum[i]` ≠ active) | (shadow `od[i]` ≠ active). Sets active `out_ena` to `out_ena & ~chg`. Pins that did not change keep driving.
- DRAIN: waits DrainCycles cycles, using a counter that reloads on entry.
- APPLY: copies shadow `portselnum` and `od` to the active registers. Any shadow `portselnum[i]` ≥ IOWidth is applied as i.
- SETTLE: holds one cycle, which covers the registered output mux in `bidir_io`. Then active `out_ena` takes the shadow `out_ena`, and the block returns to IDLE.

Boundary rules:
- A commit while `busy` sets `pending`. Any number of such commits collapse into one extra run, which starts the cycle after the block returns to IDLE.
- A write to shadow registers while `busy` is dropped and sets `wr_dropped`. CTRL and STATUS accesses are always accepted.
- A commit with no differences still runs the full sequence. `chg` is 0, so `out_ena` never drops; only the final load of `out_ena` takes effect.
- A commit that clears enables: pins with `chg`=0 keep their enable until SETTLE, then take the shadow value.
- `reset_n` asserted mid-sequence: every register returns to its reset value immediately and the commit is abandoned.
- `bus_rd` and `bus_wr` in the same cycle: both are performed; the read returns the pre-write value.

## Timing
- Read: `bus_rdata` is valid in cycle T+1 for `bus_rd` sampled at edge T, and holds until the next read.
- Shadow write: visible to a read issued in the next cycle.
- Commit sampled at edge T, with D = DrainCycles:
  - `busy`=1 and masked `out_ena` from T+1.
  - Active `portselnum`/`od` update at T+1+D+1.
  - Final `out_ena` at T+1+D+2, in the same edge that `busy` returns to 0.
  - For D=2: mask at T+1, switch at T+4, enable at T+5.
- The active outputs are registers only; no combinational path runs from the bus to them.

## Structure
- Package `bidir_io_cfg_pkg` holds:
  - the state enum;
  - the address constants `ADDR_ENA_LO`, `ADDR_ENA_HI`, `ADDR_OD_LO`, `ADDR_OD_HI`, `ADDR_CTRL`, `ADDR_STATUS`;
  - the STATUS bit indices.
- One sub-module, `bidir_io_cfg_regs`, holds the shadow register file and the read mux. The sequencer and active registers stay at the top level.

## Test plan
- Reset, then read 0x05 -> 0x00000005. Read 0x40 -> 0. `out_ena` = 0.
- Write 0x40=0xF, commit from identity -> `out_ena` never masks, becomes 0xF at T+5, `busy` high T+1..T+4.
- With enables 0xF, write `portselnum[1]`=3, commit -> `out_ena`=0xD at T+1. `portselnum[1]`=3 at T+4. `out_ena`=0xF at T+5.
- Write `portselnum[2]`=200, commit -> active `portselnum[2]`=2.
- Commit, then during `busy` write `portselnum[0]`=7 and issue two more commits -> the write is dropped and STATUS reads 0x7. A second sequence starts right after the first; a later STATUS read shows bit2 cleared.
- Assert `reset_n` low at T+2 of a commit -> `out_ena`=0, `portselnum` = identity, `busy`=0 with no clock edge needed.
